inc16_scheduler: RTL

//   Round-robin scheduler that shares one WIDTH-bit incrementer (+1, half-adder

---
 rtl/inc16_scheduler.sv | 132 +++++++++++++
 1 files changed

// File: rtl/inc16_scheduler.sv
// Round-robin scheduler sharing one WIDTH-bit +1 ripple incrementer among NREQ requesters.
// Latency: 3 cycles per operation (IDLE grant -> CALC -> RESP with 1-cycle registered ack).
// Backpressure: requesters hold req/operand until ack; req is only sampled while idle.
module inc16_scheduler #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   operand,
  output logic [NREQ-1:0]         ack,
  output logic [WIDTH-1:0]        result,
  output logic                    ovf,
  output logic [IW-1:0]           owner,
  output logic                    busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [NREQ-1:0] ONE_HOT_0 = {{(NREQ-1){1'b0}}, 1'b1};
  localparam logic [IW-1:0]   LAST_IDX  = IW'(NREQ - 1);

  state_t            state;
  state_t            state_nxt;
  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     scan_idx;
  logic [IW-1:0]     win_idx;
  logic              win_vld;
  logic              grant;
  logic [NREQ-1:0]   ack_nxt;
  logic [NREQ-1:0]   ack_reg;
  logic [WIDTH-1:0]  op_reg;
  logic [WIDTH-1:0]  res_reg;
  logic              ovf_reg;
  logic [WIDTH-1:0]  inc_sum;
  logic [WIDTH:0]    carry;

  // Round-robin pick: scan rr_ptr+1, rr_ptr+2, ... wrapping at NREQ, first set req wins.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    scan_idx = rr_ptr;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = (scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1;
      if (!win_vld && req[scan_idx]) begin
        win_vld = 1'b1;
        win_idx = scan_idx;
      end
    end
  end

  // Shared incrementer: half-adder ripple chain with the +1 injected as carry-in.
  assign carry[0] = 1'b1;
  for (genvar i = 0; i < WIDTH; i++) begin : g_ha
    assign inc_sum[i]   = op_reg[i] ^ carry[i];
    assign carry[i+1]   = op_reg[i] & carry[i];
  end

  // Next-state, grant strobe and the ack pattern to register on entry to RESP.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    ack_nxt   = '0;
    case (state)
      S_IDLE: begin
        if (win_vld) begin
          grant     = 1'b1;
          state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        ack_nxt   = ONE_HOT_0 << owner;
        state_nxt = S_RESP;
      end
      S_RESP: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // On grant, remember the winner and take a private copy of its operand.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= LAST_IDX;
      owner  <= '0;
      op_reg <= '0;
    end else if (grant) begin
      rr_ptr <= win_idx;
      owner  <= win_idx;
      op_reg <= operand[win_idx*WIDTH +: WIDTH];
    end
  end

  // Capture the increment in CALC; result/ovf then hold until the next operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_reg <= '0;
      ovf_reg <= 1'b0;
      ack_reg <= '0;
    end else begin
      ack_reg <= ack_nxt;
      if (state == S_CALC) begin
        res_reg <= inc_sum;
        ovf_reg <= carry[WIDTH];
      end
    end
  end

  assign ack    = ack_reg;
  assign result = res_reg;
  assign ovf    = ovf_reg;
  assign busy   = (state != S_IDLE);

endmodule
